// File: rtl/acc_rf_pkg.sv
// acc_rf_pkg: default sizing constants and a ceiling-log2 helper for the accumulator register file
package acc_rf_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int NUM_REGS_DEF = 9;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int SEL_W_DEF = clog2(NUM_REGS_DEF);
endpackage

// File: rtl/acc_register_file_rf_read_port.sv
// rf_read_port: one combinational read port with range check, write bypass and valid lookup
module rf_read_port #(
    parameter int DATA_W = 16,
    parameter int NUM_REGS = 9,
    parameter int SEL_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             valid,
    input  logic [SEL_W-1:0]                rd_sel,
    input  logic                            wr_en,
    input  logic [SEL_W-1:0]                wr_sel,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               rd_val,
    output logic                            rd_vld
);
    logic in_range, hit;
    always_comb begin
        in_range = 32'(rd_sel) < NUM_REGS;
        // wr_en already implies an in-range wr_sel
        hit = BYPASS && wr_en && (wr_sel == rd_sel);
        rd_val = hit ? wr_data : in_range ? regs[rd_sel] : '0;
        rd_vld = hit | (in_range & valid[rd_sel]);
    end
endmodule

// File: rtl/acc_register_file.sv
// acc_register_file: general registers plus accumulator res, two read ports, bypass and select-error flag
module acc_register_file
    import acc_rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter bit BYPASS = 1'b1,
    parameter logic [DATA_W-1:0] RES_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_we,
    input  logic              copyout,
    input  logic              reg_we,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [SEL_W-1:0]  rd_sel_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] res_val,
    output logic [DATA_W-1:0] rd_val_a,
    output logic [DATA_W-1:0] rd_val_b,
    output logic              rd_vld_a,
    output logic              rd_vld_b,
    output logic              sel_err
);
    if ((1 << SEL_W) < NUM_REGS) begin : g_sel_w_check
        $error("SEL_W too narrow for NUM_REGS");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0] valid;
    logic [DATA_W-1:0] res, wr_val;
    logic wr_req, wr_ok, wr_en;

    always_comb begin
        wr_req = reg_we | copyout;
        wr_ok = 32'(wr_sel) < NUM_REGS;
        wr_en = wr_req & wr_ok;
        // reg_we outranks copyout; copyout takes res as it stood before the edge
        wr_val = reg_we ? write_data : res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            valid <= '0;
            res <= RES_RESET;
            sel_err <= 1'b0;
        end else begin
            if (res_we) res <= write_data;
            if (wr_en) begin
                regs[wr_sel] <= wr_val;
                valid[wr_sel] <= 1'b1;
            end
            sel_err <= wr_req & ~wr_ok;
        end
    end

    assign res_val = res;

    rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .BYPASS(BYPASS)) u_port_a (
        .regs(regs), .valid(valid), .rd_sel(rd_sel_a), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_val), .rd_val(rd_val_a), .rd_vld(rd_vld_a)
    );

    rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .BYPASS(BYPASS)) u_port_b (
        .regs(regs), .valid(valid), .rd_sel(rd_sel_b), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_val), .rd_val(rd_val_b), .rd_vld(rd_vld_b)
    );
endmodule
